// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//
// UART transmit engine. Accepts one data word over a valid/ready handshake
// and serialises it LSB-first as: start bit, DATA_W data bits, optional
// parity bit, then one or two stop bits. Each bit is held for
// max(cfg_baud_div, 1) clock cycles, timed by an internal divider.
// The configuration is sampled together with the word, so cfg_* inputs may
// change freely while a frame is on the line.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-low reset
//   tx_valid       word available on tx_data
//   tx_data        word to send, LSB transmitted first
//   tx_ready       block accepts a word on this cycle's rising edge
//   cfg_baud_div   clock cycles per bit (0 behaves as 1)
//   cfg_parity_en  append a parity bit after the data bits
//   cfg_parity_odd 1 = odd parity, 0 = even parity
//   cfg_two_stop   1 = two stop bits, 0 = one stop bit
//   tx_bit         serial line, idles high
//   tx_busy        frame in progress
//   tx_done        one-cycle pulse on the last cycle of the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    input  logic [DIV_W-1:0]  cfg_baud_div,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    input  logic              cfg_two_stop,
    output logic              tx_bit,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e             state_q,     state_d;
    logic [DIV_W-1:0]   cnt_q,       cnt_d;        // cycles left in current bit
    logic [IDX_W-1:0]   idx_q,       idx_d;        // data bit currently on the line
    logic               stop_q,      stop_d;       // second stop bit in progress
    logic [DATA_W-1:0]  data_q,      data_d;       // remaining data, shifted right
    logic [DIV_W-1:0]   div_q,       div_d;
    logic               par_en_q,    par_en_d;
    logic               two_stop_q,  two_stop_d;
    logic               par_bit_q,   par_bit_d;
    logic               tx_bit_q,    tx_bit_d;
    logic               ready_en_q;                // holds tx_ready low until the first edge out of reset

    logic               bit_end;
    logic               accept;
    logic               done;
    logic [DIV_W-1:0]   reload_cfg;
    logic [DIV_W-1:0]   reload_lat;

    // Divider reload values: a bit lasts (reload + 1) cycles, and 0 behaves as 1.
    assign reload_cfg = (cfg_baud_div == '0) ? '0 : cfg_baud_div - DIV_W'(1);
    assign reload_lat = (div_q == '0) ? '0 : div_q - DIV_W'(1);

    assign bit_end  = (cnt_q == '0);
    assign tx_ready = (state_q == S_IDLE) && ready_en_q;
    assign accept   = tx_valid && tx_ready;

    // NOTE: every always_comb output gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_d     = stop_q;
        data_d     = data_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        par_bit_d  = par_bit_q;
        tx_bit_d   = tx_bit_q;
        done       = 1'b0;

        // Inside a bit, count down; boundaries below override this.
        if (state_q != S_IDLE && !bit_end) begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                tx_bit_d = 1'b1;
                if (accept) begin
                    data_d     = tx_data;
                    div_d      = cfg_baud_div;
                    par_en_d   = cfg_parity_en;
                    two_stop_d = cfg_two_stop;
                    par_bit_d  = (^tx_data) ^ cfg_parity_odd;
                    cnt_d      = reload_cfg;
                    idx_d      = '0;
                    stop_d     = 1'b0;
                    tx_bit_d   = 1'b0;
                    state_d    = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    tx_bit_d = data_q[0];
                    data_d   = data_q >> 1;
                    idx_d    = '0;
                    cnt_d    = reload_lat;
                    state_d  = S_DATA;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d = reload_lat;
                    if (idx_q == LAST_IDX) begin
                        if (par_en_q) begin
                            tx_bit_d = par_bit_q;
                            state_d  = S_PARITY;
                        end else begin
                            tx_bit_d = 1'b1;
                            stop_d   = 1'b0;
                            state_d  = S_STOP;
                        end
                    end else begin
                        tx_bit_d = data_q[0];
                        data_d   = data_q >> 1;
                        idx_d    = idx_q + IDX_W'(1);
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    tx_bit_d = 1'b1;
                    stop_d   = 1'b0;
                    cnt_d    = reload_lat;
                    state_d  = S_STOP;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !stop_q) begin
                        stop_d = 1'b1;
                        cnt_d  = reload_lat;
                    end else begin
                        done     = 1'b1;
                        tx_bit_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end

            default: begin
                tx_bit_d = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            data_q     <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_bit_q   <= 1'b1;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_q     <= stop_d;
            data_q     <= data_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            par_bit_q  <= par_bit_d;
            tx_bit_q   <= tx_bit_d;
            ready_en_q <= 1'b1;
        end
    end

    assign tx_bit  = tx_bit_q;
    assign tx_busy = (state_q != S_IDLE);
    assign tx_done = done;

endmodule

// File: tb/tb_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Self-checking bench for uart_tx_framer. Two instances: an 8-bit one with a
// 16-bit divisor, and a 5-bit one with a 3-bit divisor so the all-ones
// divisor can be exercised in a short run. Expected line waveforms come from
// a frame model that lists the bits of a frame and repeats each one for the
// bit time; every cycle of a frame is compared as {tx_bit, tx_busy, tx_done,
// tx_ready}.
// ---------------------------------------------------------------------------
module tb_uart_tx_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 8-bit instance
    logic        v8;
    logic [7:0]  d8;
    logic        r8;
    logic [15:0] div8;
    logic        pe8, po8, ts8;
    logic        b8, bs8, dn8;

    // 5-bit instance
    logic        v5;
    logic [4:0]  d5;
    logic        r5;
    logic [2:0]  div5;
    logic        pe5, po5, ts5;
    logic        b5, bs5, dn5;

    uart_tx_framer #(.DATA_W(8), .DIV_W(16)) dut8 (
        .clock          (clk),
        .reset          (rst_n),
        .tx_valid       (v8),
        .tx_data        (d8),
        .tx_ready       (r8),
        .cfg_baud_div   (div8),
        .cfg_parity_en  (pe8),
        .cfg_parity_odd (po8),
        .cfg_two_stop   (ts8),
        .tx_bit         (b8),
        .tx_busy        (bs8),
        .tx_done        (dn8)
    );

    uart_tx_framer #(.DATA_W(5), .DIV_W(3)) dut5 (
        .clock          (clk),
        .reset          (rst_n),
        .tx_valid       (v5),
        .tx_data        (d5),
        .tx_ready       (r5),
        .cfg_baud_div   (div5),
        .cfg_parity_en  (pe5),
        .cfg_parity_odd (po5),
        .cfg_two_stop   (ts5),
        .tx_bit         (b5),
        .tx_busy        (bs5),
        .tx_done        (dn5)
    );

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Frame model: start, data LSB-first, optional parity, stop bit(s),
    // each bit repeated for max(div,1) cycles.
    task automatic build(input logic [8:0] d, input int w, input bit pen, input bit podd,
                         input bit two, input int div);
        bit bits[$];
        int ones;
        int per;
        ones = 0;
        exp_q.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pen) bits.push_back(bit'(ones % 2) ^ podd);
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        per = (div == 0) ? 1 : div;
        foreach (bits[i]) repeat (per) exp_q.push_back(bits[i]);
    endtask

    function automatic logic [3:0] obs(input bit sel);
        return sel ? {b5, bs5, dn5, r5} : {b8, bs8, dn8, r8};
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [8:0] d, input int div,
                         input bit pen, input bit podd, input bit two);
        if (sel) begin
            v5 = v; d5 = d[4:0]; div5 = div[2:0]; pe5 = pen; po5 = podd; ts5 = two;
        end else begin
            v8 = v; d8 = d[7:0]; div8 = div[15:0]; pe8 = pen; po8 = podd; ts8 = two;
        end
    endtask

    // Called at a negedge while the instance is idle with a word presented:
    // the next rising edge accepts it. On the first frame cycle the inputs
    // are replaced by the "next" values, which must not disturb this frame.
    // Ends on the negedge of the idle cycle following the frame.
    task automatic frame(input string tag, input bit sel, input logic [8:0] d, input int div,
                         input bit pen, input bit podd, input bit two, input int limit,
                         input logic nv, input logic [8:0] nd, input int ndiv,
                         input bit npen, input bit npodd, input bit ntwo);
        int n;
        build(d, sel ? 5 : 8, pen, podd, two, div);
        n = exp_q.size();
        for (int k = 1; k <= n; k++) begin
            if (k > limit) return;
            @(negedge clk);
            check($sformatf("%s cyc%0d", tag, k), 32'(obs(sel)),
                  32'({exp_q[k-1], 1'b1, (k == n), 1'b0}));
            if (k == 1) drive(sel, nv, nd, ndiv, npen, npodd, ntwo);
        end
        @(negedge clk);
        check($sformatf("%s idle", tag), 32'(obs(sel)), 32'(4'b1001));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] cd, nd;
        int         cdiv, ndiv;
        bit         cpen, cpodd, ctwo, npen, npodd, ntwo, b2b;
        int         nfr;

        rst_n = 1'b0;
        drive(0, 0, 9'h0, 1, 0, 0, 0);
        drive(1, 0, 9'h0, 1, 0, 0, 0);

        // Reset state, then release.
        #12;
        check("reset dut8", 32'(obs(0)), 32'(4'b1000));
        check("reset dut5", 32'(obs(1)), 32'(4'b1000));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready dut8", 32'(obs(0)), 32'(4'b1001));
        check("ready dut5", 32'(obs(1)), 32'(4'b1001));

        // Basic frame; cfg scrambled mid-frame must not matter.
        drive(0, 1, 9'hA5, 4, 0, 0, 0);
        frame("basic", 0, 9'hA5, 4, 0, 0, 0, 1000, 0, 9'h1FF, 9, 1, 1, 1);

        // Parity modes.
        drive(0, 1, 9'hA5, 2, 1, 0, 0);
        frame("par_even", 0, 9'hA5, 2, 1, 0, 0, 1000, 0, 9'h00, 3, 0, 1, 1);
        drive(0, 1, 9'hA5, 2, 1, 1, 0);
        frame("par_odd", 0, 9'hA5, 2, 1, 1, 0, 1000, 0, 9'h00, 3, 0, 0, 1);

        // Zero divisor, two stop bits.
        drive(0, 1, 9'h00, 0, 0, 0, 1);
        frame("div0_2stop", 0, 9'h00, 0, 0, 0, 1, 1000, 0, 9'hFF, 5, 1, 0, 0);

        // Back-to-back with divisor change during the first frame.
        drive(0, 1, 9'h3C, 4, 0, 0, 0);
        frame("b2b_a", 0, 9'h3C, 4, 0, 0, 0, 1000, 1, 9'hC3, 8, 0, 0, 0);
        frame("b2b_b", 0, 9'hC3, 8, 0, 0, 0, 1000, 0, 9'h00, 1, 0, 0, 0);

        // Reset during the third data bit (cycles 13..16 at div 4).
        drive(0, 1, 9'h96, 4, 0, 0, 0);
        frame("rst_pre", 0, 9'h96, 4, 0, 0, 0, 13, 0, 9'h00, 4, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(obs(0)), 32'(4'b1000));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_hold%0d", i), 32'(obs(0)), 32'(4'b1000));
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release", 32'(obs(0)), 32'(4'b1001));
        drive(0, 1, 9'h5A, 4, 0, 0, 0);
        frame("post_rst", 0, 9'h5A, 4, 0, 0, 0, 1000, 0, 9'h00, 4, 0, 0, 0);

        // 5-bit instance: plain frame, then all-ones divisor with odd parity.
        drive(1, 1, 9'h15, 3, 0, 0, 0);
        frame("w5", 1, 9'h15, 3, 0, 0, 0, 1000, 0, 9'h0A, 0, 1, 1, 1);
        drive(1, 1, 9'h0B, 7, 1, 1, 1);
        frame("w5_divmax", 1, 9'h0B, 7, 1, 1, 1, 1000, 0, 9'h00, 1, 0, 0, 0);

        // Randomised frames on the 8-bit instance, some back-to-back.
        nfr = 24;
        cd = 9'($urandom_range(0, 255)); cdiv = $urandom_range(0, 5);
        cpen = 1'($urandom); cpodd = 1'($urandom); ctwo = 1'($urandom);
        drive(0, 1, cd, cdiv, cpen, cpodd, ctwo);
        for (int i = 0; i < nfr; i++) begin
            nd = 9'($urandom_range(0, 255)); ndiv = $urandom_range(0, 5);
            npen = 1'($urandom); npodd = 1'($urandom); ntwo = 1'($urandom);
            b2b = (i < nfr - 1) ? 1'($urandom) : 1'b0;
            frame($sformatf("rnd%0d", i), 0, cd, cdiv, cpen, cpodd, ctwo, 1000,
                  b2b, nd, ndiv, npen, npodd, ntwo);
            if (i < nfr - 1 && !b2b) drive(0, 1, nd, ndiv, npen, npodd, ntwo);
            cd = nd; cdiv = ndiv; cpen = npen; cpodd = npodd; ctwo = ntwo;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
